weight_bram_loader: RTL

- Upstream stage of the dual-BRAM weight reader; fills both weight BRAMs before the read side consumes them.
- Accepts a 32-bit valid/ready word stream (from the AXI front end) and packs consecutive words into 5*MAC_NUM-bit weight lines.
- Writes each completed line to the same address in BRAM A and BRAM B, so the reader can fetch lines addr and addr+1 in parallel.
- Reports progress, completion and address overflow to the controller.

---
 rtl/weight_bram_loader_if.sv | 10 +
 rtl/weight_bram_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/weight_bram_loader_if.sv
// 32-bit weight word stream between the AXI front end and the BRAM loader.
interface weight_bram_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        s_last;

    modport master (output s_data, s_valid, s_last, input s_ready);
    modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/weight_bram_loader.sv
// Packs the 32-bit weight stream into 5*MAC_NUM-bit lines and writes each
// line to the same address in both weight BRAMs.
module weight_bram_loader #(
    parameter int MAC_NUM            = 256,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    localparam int LINE_W            = 5 * MAC_NUM,
    localparam int WPL               = LINE_W / 32,
    localparam int AW                = BRAM_ADDRESS_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    weight_bram_loader_if.slave s,
    output logic [LINE_W-1:0]   bram_wr_data,
    output logic [AW-1:0]       bram_wr_addr,
    output logic                bram_we_A,
    output logic                bram_we_B,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_overflow,
    output logic [AW:0]         lines_written
);
    localparam int KW = $clog2(WPL);
    localparam logic [AW-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k;
    logic [AW-1:0]     addr;
    logic [LINE_W-1:0] pack;
    logic [LINE_W-1:0] line;
    logic              line_last;
    logic              accept;
    logic              complete;

    assign s.s_ready = (state == FILL);
    assign accept    = s.s_valid && s.s_ready;
    assign complete  = accept && (k == KW'(WPL - 1) || s.s_last);

    assign bram_we_A = (state == WRITE);
    assign bram_we_B = (state == WRITE);
    assign load_busy = (state == FILL) || (state == WRITE);
    assign load_done = (state == DONE);

    always_comb begin
        line = pack;
        line[{k, 5'b0} +: 32] = s.s_data;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (load_start) state_nxt = FILL;
            FILL: begin
                if (load_start)    state_nxt = FILL;
                else if (complete) state_nxt = WRITE;
            end
            WRITE: begin
                if (load_start)            state_nxt = FILL;
                else if (line_last)        state_nxt = DONE;
                else if (addr == ADDR_MAX) state_nxt = DONE;
                else                       state_nxt = FILL;
            end
            DONE:  state_nxt = load_start ? FILL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Write address/data are captured when the line completes so they hold
    // steady outside WRITE while the pack register refills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k             <= '0;
            addr          <= '0;
            pack          <= '0;
            line_last     <= 1'b0;
            bram_wr_data  <= '0;
            bram_wr_addr  <= '0;
            load_overflow <= 1'b0;
            lines_written <= '0;
        end else if (load_start) begin
            k             <= '0;
            addr          <= '0;
            pack          <= '0;
            line_last     <= 1'b0;
            load_overflow <= 1'b0;
            lines_written <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        pack <= line;
                        k    <= k + 1'b1;
                    end
                    if (complete) begin
                        bram_wr_data <= line;
                        bram_wr_addr <= addr;
                        line_last    <= s.s_last;
                    end
                end
                WRITE: begin
                    lines_written <= lines_written + 1'b1;
                    if (!line_last) begin
                        if (addr == ADDR_MAX) begin
                            load_overflow <= 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                            k    <= '0;
                            pack <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
